// File: rtl/ajuste_pkg.sv
// Shared types and constants for the time-set sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ajuste_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EDIT    = 2'd2,
        COMMIT  = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        CAMPO_H = 2'd0,
        CAMPO_M = 2'd1,
        CAMPO_S = 2'd2
    } campo_t;

    localparam int MAX_MIN_SEG       = 59;
    localparam int H_MAX_RELOGIO_DEF = 23;
    localparam int H_MAX_TIMER_DEF   = 99;

    // Field selection order H -> M -> S -> H.
    function automatic campo_t proximo_campo(input campo_t c);
        case (c)
            CAMPO_H: proximo_campo = CAMPO_M;
            CAMPO_M: proximo_campo = CAMPO_S;
            default: proximo_campo = CAMPO_H;
        endcase
    endfunction

    // Blank-enable bit for a field, packed as {H,M,S}.
    function automatic logic [2:0] campo_onehot(input campo_t c);
        case (c)
            CAMPO_H: campo_onehot = 3'b100;
            CAMPO_M: campo_onehot = 3'b010;
            CAMPO_S: campo_onehot = 3'b001;
            default: campo_onehot = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/ajuste_controle_if.sv
// Bundle between the mode decoder / buttons and the time-set sequencer.
// Latency: n/a (wires only).
// Backpressure: none; all strobes are single-cycle pulses.
// slave  = sequencer side (consumes mode/flag/button/seed, drives adj/status/load).
// master = environment side.
interface ajuste_controle_if;
    logic       modo_ajuste_relogio;
    logic       modo_ajuste_timer;
    logic       flag_ajuste_relogio;
    logic       flag_ajuste_timer;
    logic       btn_sel;
    logic       btn_inc;
    logic       btn_dec;
    logic       tick_blink;
    logic [6:0] seed_h;
    logic [5:0] seed_m;
    logic [5:0] seed_s;
    logic [6:0] adj_h;
    logic [5:0] adj_m;
    logic [5:0] adj_s;
    logic [1:0] campo;
    logic [2:0] blink_mask;
    logic       ativo;
    logic       load_relogio;
    logic       load_timer;

    modport slave (
        input  modo_ajuste_relogio, modo_ajuste_timer,
        input  flag_ajuste_relogio, flag_ajuste_timer,
        input  btn_sel, btn_inc, btn_dec, tick_blink,
        input  seed_h, seed_m, seed_s,
        output adj_h, adj_m, adj_s, campo, blink_mask,
        output ativo, load_relogio, load_timer
    );

    modport master (
        output modo_ajuste_relogio, modo_ajuste_timer,
        output flag_ajuste_relogio, flag_ajuste_timer,
        output btn_sel, btn_inc, btn_dec, tick_blink,
        output seed_h, seed_m, seed_s,
        input  adj_h, adj_m, adj_s, campo, blink_mask,
        input  ativo, load_relogio, load_timer
    );
endinterface

// File: rtl/ajuste_campo.sv
// Modular up/down register for one H/M/S field, wrapping between 0 and max.
// Latency: load/inc/dec visible on value one clock later.
// Backpressure: none; inc and dec together cancel out.
// Ports: clk, reset (async active-low), load+seed, inc, dec, max, value.
module ajuste_campo #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] seed,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] max,
    output logic [W-1:0] value
);
    logic [W-1:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = seed;
        end else if (inc && !dec) begin
            // >= so an out-of-range seed still falls back into range.
            value_d = (value_q >= max) ? '0 : value_q + 1'b1;
        end else if (dec && !inc) begin
            value_d = (value_q == '0 || value_q > max) ? max : value_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) value_q <= '0;
        else        value_q <= value_d;
    end

    assign value = value_q;
endmodule

// File: rtl/ajuste_controle.sv
// Time-set sequencer: captures seed H:M:S, edits it with buttons, issues a load strobe on exit.
// Latency: button -> adj_* next edge; exit flag -> load strobe next edge (one cycle wide).
// Backpressure: none; inputs are pulses/levels, a flag outranks any same-cycle button.
// Ports: clk, reset (async active-low), bus (ajuste_controle_if.slave).
// Build option AJUSTE_BLINK_EN: blink the selected field on tick_blink while editing.
module ajuste_controle
    import ajuste_pkg::*;
#(
    parameter int H_MAX_RELOGIO = H_MAX_RELOGIO_DEF,
    parameter int H_MAX_TIMER   = H_MAX_TIMER_DEF
) (
    input  logic               clk,
    input  logic               reset,
    ajuste_controle_if.slave   bus
);
    estado_t state_q, state_d;
    campo_t  campo_q, campo_d;
    logic    alvo_q,  alvo_d;   // 0 = clock, 1 = timer

    logic       carga;          // load shadow from seed
    logic       passo;          // buttons may act this cycle
    logic       flag_alvo;
    logic       aborta;
    logic [6:0] h_max;

    assign flag_alvo = alvo_q ? bus.flag_ajuste_timer : bus.flag_ajuste_relogio;
    // Leaving the target mode without its flag, or the other adjust mode appearing.
    assign aborta    = alvo_q ? (!bus.modo_ajuste_timer   || bus.modo_ajuste_relogio)
                              : (!bus.modo_ajuste_relogio || bus.modo_ajuste_timer);
    assign h_max     = alvo_q ? 7'(H_MAX_TIMER) : 7'(H_MAX_RELOGIO);

    always_comb begin
        state_d = state_q;
        campo_d = campo_q;
        alvo_d  = alvo_q;
        carga   = 1'b0;
        passo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.modo_ajuste_relogio || bus.modo_ajuste_timer) begin
                    alvo_d  = !bus.modo_ajuste_relogio;   // clock wins a tie
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                if (aborta) begin
                    state_d = IDLE;
                end else begin
                    carga   = 1'b1;
                    campo_d = CAMPO_H;
                    state_d = EDIT;
                end
            end
            EDIT: begin
                if (flag_alvo) begin
                    state_d = COMMIT;
                end else if (aborta) begin
                    state_d = IDLE;
                end else begin
                    passo = 1'b1;
                    if (bus.btn_sel) campo_d = proximo_campo(campo_q);
                end
            end
            default: state_d = IDLE;                     // COMMIT lasts one cycle
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            campo_q <= CAMPO_H;
            alvo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            campo_q <= campo_d;
            alvo_q  <= alvo_d;
        end
    end

    // The field steps with the campo value held before any same-cycle sel.
    ajuste_campo #(.W(7)) u_campo_h (
        .clk(clk), .reset(reset), .load(carga), .seed(bus.seed_h),
        .inc(passo && bus.btn_inc && campo_q == CAMPO_H),
        .dec(passo && bus.btn_dec && campo_q == CAMPO_H),
        .max(h_max), .value(bus.adj_h)
    );
    ajuste_campo #(.W(6)) u_campo_m (
        .clk(clk), .reset(reset), .load(carga), .seed(bus.seed_m),
        .inc(passo && bus.btn_inc && campo_q == CAMPO_M),
        .dec(passo && bus.btn_dec && campo_q == CAMPO_M),
        .max(6'(MAX_MIN_SEG)), .value(bus.adj_m)
    );
    ajuste_campo #(.W(6)) u_campo_s (
        .clk(clk), .reset(reset), .load(carga), .seed(bus.seed_s),
        .inc(passo && bus.btn_inc && campo_q == CAMPO_S),
        .dec(passo && bus.btn_dec && campo_q == CAMPO_S),
        .max(6'(MAX_MIN_SEG)), .value(bus.adj_s)
    );

    assign bus.campo        = campo_q;
    assign bus.ativo        = (state_q == EDIT);
    assign bus.load_relogio = (state_q == COMMIT) && !alvo_q;
    assign bus.load_timer   = (state_q == COMMIT) &&  alvo_q;

`ifdef AJUSTE_BLINK_EN
    logic fase_q, fase_d;

    // Any button keeps the field visible while it is being stepped.
    always_comb begin
        fase_d = 1'b0;
        if (state_q == EDIT) begin
            if (bus.btn_sel || bus.btn_inc || bus.btn_dec) fase_d = 1'b0;
            else if (bus.tick_blink)                        fase_d = !fase_q;
            else                                            fase_d = fase_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fase_q <= 1'b0;
        else        fase_q <= fase_d;
    end

    assign bus.blink_mask = (state_q == EDIT && fase_q) ? campo_onehot(campo_q) : 3'b000;
`else
    logic unused_tick;
    assign unused_tick    = bus.tick_blink;
    assign bus.blink_mask = 3'b000;
`endif
endmodule

// File: tb/tb_ajuste_controle.sv
// Bench for ajuste_controle: directed and random button sequences against an H:M:S model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ajuste_controle;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ajuste_controle_if bus ();
    ajuste_controle dut (.clk(clk), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int f[3];        // expected H, M, S
    int c;           // expected selected field index
    int alvo_m;      // 0 clock, 1 timer
    int ph;          // expected blink phase

    function automatic int mx(input int k, input int t);
        if (k == 0) return (t != 0) ? 99 : 23;
        return 59;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input int e_ativo, input int e_lr, input int e_lt);
        logic [2:0] m;
        logic [2:0] top;
        top = 3'b100;
        m   = 3'b000;
`ifdef AJUSTE_BLINK_EN
        if (e_ativo != 0 && ph != 0) m = top >> c;
`endif
        chk({tag, "_h"}, 32'(bus.adj_h), f[0]);
        chk({tag, "_m"}, 32'(bus.adj_m), f[1]);
        chk({tag, "_s"}, 32'(bus.adj_s), f[2]);
        chk({tag, "_campo"}, 32'(bus.campo), c);
        chk({tag, "_ativo"}, 32'(bus.ativo), e_ativo);
        chk({tag, "_mask"}, 32'(bus.blink_mask), 32'(m));
        chk({tag, "_ldr"}, 32'(bus.load_relogio), e_lr);
        chk({tag, "_ldt"}, 32'(bus.load_timer), e_lt);
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        bus.modo_ajuste_relogio = 1'b0;
        bus.modo_ajuste_timer   = 1'b0;
        bus.flag_ajuste_relogio = 1'b0;
        bus.flag_ajuste_timer   = 1'b0;
        bus.btn_sel = 1'b0;
        bus.btn_inc = 1'b0;
        bus.btn_dec = 1'b0;
        bus.tick_blink = 1'b0;
    endtask

    task automatic enter(input int t, input int h, input int m, input int s);
        bus.seed_h = 7'(h);
        bus.seed_m = 6'(m);
        bus.seed_s = 6'(s);
        bus.modo_ajuste_relogio = (t == 0);
        bus.modo_ajuste_timer   = (t != 0);
        alvo_m = t;
        edge1();
        check_out("capture", 0, 0, 0);
        edge1();
        f[0] = h; f[1] = m; f[2] = s; c = 0; ph = 0;
        check_out("enter", 1, 0, 0);
    endtask

    task automatic step(input logic sel, input logic inc, input logic dec, input logic tb,
                        input string tag);
        bus.btn_sel = sel; bus.btn_inc = inc; bus.btn_dec = dec; bus.tick_blink = tb;
        edge1();
        bus.btn_sel = 1'b0; bus.btn_inc = 1'b0; bus.btn_dec = 1'b0; bus.tick_blink = 1'b0;
        if (inc && !dec) f[c] = (f[c] + 1) % (mx(c, alvo_m) + 1);
        if (dec && !inc) f[c] = (f[c] + mx(c, alvo_m)) % (mx(c, alvo_m) + 1);
        if (sel) c = (c + 1) % 3;
        if (sel || inc || dec) ph = 0;
        else if (tb)           ph = 1 - ph;
        check_out(tag, 1, 0, 0);
    endtask

    task automatic commit(input int t, input logic inc);
        bus.flag_ajuste_relogio = (t == 0);
        bus.flag_ajuste_timer   = (t != 0);
        bus.modo_ajuste_relogio = 1'b0;
        bus.modo_ajuste_timer   = 1'b0;
        bus.btn_inc = inc;
        check_out("flag_cycle", 1, 0, 0);
        edge1();
        clr_in();
        check_out("commit", 0, (t == 0), (t != 0));
        edge1();
        check_out("post_commit", 0, 0, 0);
    endtask

    task automatic abort_t(input string tag);
        bus.modo_ajuste_relogio = 1'b0;
        bus.modo_ajuste_timer   = 1'b0;
        edge1();
        check_out(tag, 0, 0, 0);
        edge1();
        check_out({tag, "_idle"}, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        clr_in();
        bus.seed_h = '0; bus.seed_m = '0; bus.seed_s = '0;
        f[0] = 0; f[1] = 0; f[2] = 0; c = 0; ph = 0; alvo_m = 0;
        #2;
        check_out("reset", 0, 0, 0);
        #21 reset = 1'b1;
        edge1();
        check_out("idle", 0, 0, 0);

        // Clock set 12:34:56 -> 15:33:56
        enter(0, 12, 34, 56);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, "t1_inc");
        step(1, 0, 0, 0, "t1_sel");
        step(0, 0, 1, 0, "t1_dec");
        chk("t1_h_const", 32'(bus.adj_h), 15);
        chk("t1_m_const", 32'(bus.adj_m), 33);
        chk("t1_s_const", 32'(bus.adj_s), 56);
        commit(0, 1'b0);

        // Wrap limits
        enter(0, 23, 10, 20);
        step(0, 1, 0, 0, "t2_h23_inc");
        chk("t2_h_zero", 32'(bus.adj_h), 0);
        step(0, 0, 1, 0, "t2_h0_dec");
        chk("t2_h_23", 32'(bus.adj_h), 23);
        abort_t("t2_abort_r");
        enter(1, 99, 5, 0);
        step(0, 1, 0, 0, "t2_h99_inc");
        chk("t2_h99_zero", 32'(bus.adj_h), 0);
        step(1, 0, 0, 0, "t2_sel1");
        step(1, 0, 0, 0, "t2_sel2");
        step(0, 0, 1, 0, "t2_s0_dec");
        chk("t2_s_59", 32'(bus.adj_s), 59);
        step(0, 1, 1, 0, "t2_incdec");
        abort_t("t2_abort_t");

        // Abort without flag
        enter(0, 7, 8, 9);
        step(0, 1, 0, 0, "t3_inc");
        abort_t("t3_abort");

        // Simultaneous sel+inc, then flag with inc
        enter(0, 4, 58, 30);
        step(1, 0, 0, 0, "t4_sel");
        step(1, 1, 0, 0, "t4_sel_inc");
        chk("t4_m_59", 32'(bus.adj_m), 59);
        chk("t4_campo_s", 32'(bus.campo), 2);
        commit(0, 1'b1);

        // Asynchronous reset mid-EDIT
        enter(1, 50, 40, 30);
        step(0, 1, 0, 0, "t5_inc");
        #2 reset = 1'b0;
        #1;
        f[0] = 0; f[1] = 0; f[2] = 0; c = 0; ph = 0;
        check_out("t5_async", 0, 0, 0);
        clr_in();
        edge1();
        check_out("t5_held", 0, 0, 0);
        #2 reset = 1'b1;
        enter(0, 1, 2, 3);

        // Blink on field S
        step(1, 0, 0, 0, "t6_sel1");
        step(1, 0, 0, 0, "t6_sel2");
        step(0, 0, 0, 1, "t6_tick1");
        step(0, 0, 0, 1, "t6_tick2");
        step(0, 0, 0, 1, "t6_tick3");
        step(0, 1, 0, 0, "t6_inc");
        commit(0, 1'b0);

        // Random sessions
        for (int k = 0; k < 4; k++) begin
            t = int'($urandom_range(1, 0));
            enter(t, int'($urandom_range(mx(0, t), 0)), int'($urandom_range(59, 0)),
                  int'($urandom_range(59, 0)));
            for (int j = 0; j < 25; j++) begin
                step(($urandom_range(3, 0) == 0), ($urandom_range(2, 0) == 0),
                     ($urandom_range(2, 0) == 0), ($urandom_range(2, 0) == 0), "rnd");
            end
            commit(t, 1'($urandom_range(1, 0)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
